// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt priority controller.
//   N_REQ       : number of request lines
//   CODE_W      : width of the granted-line index
//   irq_state_t : grant FSM states (idle, interrupt asserted, one-cycle gap)
package irq_pkg;
    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } irq_state_t;
endpackage

// File: rtl/irq_priority_ctrl_penc.sv
// Highest-set-bit encoder for an 8-bit vector.
//   in   : input vector, bit 7 has highest priority
//   code : index of the highest set bit (0 when in == 0)
//   z    : 1 when no bit of in is set
module PriorityEncode8 (
    input  logic [7:0] in,
    output logic [2:0] code,
    output logic       z
);
    always_comb begin
        code = 3'd0;
        // Ascending scan: the last (highest) set bit found wins.
        for (int i = 0; i < 8; i++) begin
            if (in[i]) begin
                code = 3'(i);
            end
        end
        z = (in == 8'h00);
    end
endmodule

// File: rtl/irq_priority_ctrl.sv
// Eight-line interrupt priority controller.
// Asynchronous request lines are synchronised, rising edges are latched into
// pending bits, masked lines are filtered out and the highest remaining line
// is granted through a three-state handshake (IDLE -> ASSERT -> GAP).
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   req      : asynchronous request lines, bit 7 highest priority
//   mask_wr  : load strobe for the mask register
//   mask_din : new mask value, 1 = line disabled
//   ack      : consumer acknowledge of the current interrupt
//   irq      : interrupt valid
//   irq_code : granted line index, valid while irq = 1
//   pending  : registered pending bits
//   mask     : registered mask
module irq_priority_ctrl
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic                mask_wr,
    input  logic [N_REQ-1:0]    mask_din,
    input  logic                ack,
    output logic                irq,
    output logic [CODE_W-1:0]   irq_code,
    output logic [N_REQ-1:0]    pending,
    output logic [N_REQ-1:0]    mask
);
    // Synchroniser chain, stage-major: sync_reg[0] samples req directly.
    logic [N_REQ-1:0]  sync_reg [SYNC_STAGES];
    logic [N_REQ-1:0]  prev_reg;
    logic [N_REQ-1:0]  rise_reg;
    logic [N_REQ-1:0]  pending_reg;
    logic [N_REQ-1:0]  pending_next;
    logic [N_REQ-1:0]  mask_reg;
    logic [N_REQ-1:0]  masked;
    logic [N_REQ-1:0]  clr_vec;
    logic [CODE_W-1:0] enc_code;
    logic              enc_zero;
    logic              clr_en;
    irq_state_t        state_reg;
    irq_state_t        state_next;
    logic [CODE_W-1:0] code_reg;
    logic [CODE_W-1:0] code_next;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg[gi] <= '0;
                end else if (gi == 0) begin
                    sync_reg[gi] <= req;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    // Rising edge at the last synchroniser stage is registered once more
    // before it reaches the pending bits. prev_reg resets to 0, so a line
    // already high when reset releases is seen as a fresh rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg <= '0;
            rise_reg <= '0;
        end else begin
            prev_reg <= sync_reg[SYNC_STAGES-1];
            rise_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
        end
    end

    assign masked = pending_reg & ~mask_reg;

    PriorityEncode8 u_penc (
        .in   (masked),
        .code (enc_code),
        .z    (enc_zero)
    );

    // Grant FSM: the code is latched on entry to ASSERT and held there, so
    // later pending or mask changes cannot alter the interrupt in flight.
    always_comb begin
        state_next = state_reg;
        code_next  = code_reg;
        clr_en     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!enc_zero) begin
                    code_next  = enc_code;
                    state_next = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (ack) begin
                    clr_en     = 1'b1;
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // A new rising edge on the same edge as the acknowledge clear keeps the
    // bit set, so the re-request is not lost.
    assign clr_vec      = clr_en ? (N_REQ'(1) << code_reg) : '0;
    assign pending_next = (pending_reg & ~clr_vec) | rise_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            code_reg    <= '0;
            pending_reg <= '0;
            mask_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            code_reg    <= code_next;
            pending_reg <= pending_next;
            if (mask_wr) begin
                mask_reg <= mask_din;
            end
        end
    end

    assign irq      = (state_reg == ST_ASSERT);
    assign irq_code = code_reg;
    assign pending  = pending_reg;
    assign mask     = mask_reg;
endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Testbench for irq_priority_ctrl: directed scenarios with literal
// expectations plus a randomized run, all continuously compared against a
// behavioural model of the controller.
module tb_irq_priority_ctrl;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       mask_wr = 1'b0;
    logic [7:0] mask_din = 8'h00;
    logic       ack = 1'b0;
    logic       irq;
    logic [2:0] irq_code;
    logic [7:0] pending;
    logic [7:0] mask;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    irq_priority_ctrl #(.SYNC_STAGES(SYNC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .mask_wr  (mask_wr),
        .mask_din (mask_din),
        .ack      (ack),
        .irq      (irq),
        .irq_code (irq_code),
        .pending  (pending),
        .mask     (mask)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // hist[n] is the req value sampled n+1 edges ago; a pending bit sets
    // SYNC+1 edges after the line was first sampled high.
    logic [7:0] m_hist [0:7];
    logic [7:0] m_pend = 8'h00;
    logic [7:0] m_mask = 8'h00;
    int         m_phase = 0;   // 0 waiting, 1 interrupt out, 2 gap
    int         m_code = 0;
    logic [7:0] m_set, m_clr, m_avail;

    function automatic int top_bit(input logic [7:0] v);
        int r = 0;
        for (int i = 0; i < 8; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 8; i++) m_hist[i] = 8'h00;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 8; i++) m_hist[i] = 8'h00;
                m_pend = 8'h00; m_mask = 8'h00; m_phase = 0; m_code = 0;
            end else begin
                m_set   = m_hist[SYNC] & ~m_hist[SYNC+1];
                m_clr   = 8'h00;
                m_avail = m_pend & ~m_mask;
                if (m_phase == 0) begin
                    if (m_avail != 8'h00) begin
                        m_code = top_bit(m_avail);
                        m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    if (ack) begin
                        m_clr[m_code] = 1'b1;
                        m_phase = 2;
                    end
                end else begin
                    m_phase = 0;
                end
                m_pend = (m_pend & ~m_clr) | m_set;
                if (mask_wr) m_mask = mask_din;
                for (int i = 7; i > 0; i--) m_hist[i] = m_hist[i-1];
                m_hist[0] = req;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("model_irq", 32'(irq), 32'(m_phase == 1));
                if (m_phase == 1) chk("model_code", 32'(irq_code), 32'(m_code));
                chk("model_pending", 32'(pending), 32'(m_pend));
                chk("model_mask", 32'(mask), 32'(m_mask));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cyc(2);
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_code", 32'(irq_code), 32'h0);
        chk("reset_pending", 32'(pending), 32'h0);
        chk("reset_mask", 32'(mask), 32'h0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        cyc(2);

        // Single request: latency and acknowledge.
        req = 8'h04; cyc(1); req = 8'h00;
        cyc(2);
        chk("single_pend_k2", 32'(pending), 32'h00);
        cyc(1);
        chk("single_pend_k3", 32'(pending), 32'h04);
        chk("single_irq_k3", 32'(irq), 32'h0);
        cyc(1);
        chk("single_irq_k4", 32'(irq), 32'h1);
        chk("single_code", 32'(irq_code), 32'h2);
        ack = 1'b1; cyc(1); ack = 1'b0;
        chk("single_gap_irq", 32'(irq), 32'h0);
        chk("single_cleared", 32'(pending), 32'h00);
        cyc(3);
        chk("single_stays_low", 32'(irq), 32'h0);

        // Priority order with two simultaneous lines.
        req = 8'h41; cyc(1); req = 8'h00;
        cyc(4);
        chk("prio_first", 32'(irq_code), 32'h6);
        ack = 1'b1; cyc(1); ack = 1'b0;
        chk("prio_gap", 32'(irq), 32'h0);
        cyc(1);
        chk("prio_idle", 32'(irq), 32'h0);
        cyc(1);
        chk("prio_second_irq", 32'(irq), 32'h1);
        chk("prio_second", 32'(irq_code), 32'h0);
        ack = 1'b1; cyc(1); ack = 1'b0;
        chk("prio_empty", 32'(pending), 32'h00);
        cyc(2);

        // Masked line records pending, unmasking releases it.
        mask_wr = 1'b1; mask_din = 8'h80; cyc(1); mask_wr = 1'b0;
        req = 8'h80; cyc(1); req = 8'h00;
        cyc(6);
        chk("mask_pend", 32'(pending), 32'h80);
        chk("mask_irq", 32'(irq), 32'h0);
        mask_wr = 1'b1; mask_din = 8'h00; cyc(1); mask_wr = 1'b0;
        cyc(1);
        chk("unmask_irq", 32'(irq), 32'h1);
        chk("unmask_code", 32'(irq_code), 32'h7);
        ack = 1'b1; cyc(1); ack = 1'b0;
        cyc(2);

        // Asynchronous reset while irq is asserted, req held high.
        req = 8'h10; cyc(6);
        chk("pre_reset_irq", 32'(irq), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_irq", 32'(irq), 32'h0);
        chk("async_pending", 32'(pending), 32'h00);
        chk("async_mask", 32'(mask), 32'h00);
        cyc(2);
        rst_n = 1'b1;
        cyc(6);
        chk("held_req_grant", 32'(irq), 32'h1);
        chk("held_req_code", 32'(irq_code), 32'h4);
        req = 8'h00;
        ack = 1'b1; cyc(1); ack = 1'b0;
        cyc(3);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) req = req ^ (8'h01 << $urandom_range(7));
            mask_wr  = ($urandom_range(15) == 0);
            mask_din = 8'($urandom & $urandom);
            ack      = ($urandom_range(2) == 0);
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                cyc(2);
                rst_n = 1'b1;
            end
            cyc(1);
        end
        ack = 1'b0; mask_wr = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/irq_priority_ctrl.md
IRQ_PRIORITY_CTRL -- requirements
Module: irq_priority_ctrl

Interface
REQ-001 The block SHALL have one clock and a reset that is asynchronous and active-low.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the number of synchroniser flops per request line (legal 2..3).
REQ-003 Port clk, input, 1: rising-edge clock.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port req, input, 8: asynchronous request lines, bit 7 highest priority.
REQ-006 Port mask_wr, input, 1: write strobe for the mask register.
REQ-007 Port mask_din, input, 8: new mask value; 1 = line disabled.
REQ-008 Port ack, input, 1: consumer acknowledge of the current interrupt.
REQ-009 Port irq, output, 1: interrupt valid.
REQ-010 Port irq_code, output, 3: index of the granted line, valid while irq=1.
REQ-011 Port pending, output, 8: registered pending bits.
REQ-012 Port mask, output, 8: registered mask.

Function
REQ-013 Each req bit SHALL pass through SYNC_STAGES flops; a 0->1 transition at the last stage SHALL set the matching pending bit on the next edge.
REQ-014 Latency: with SYNC_STAGES=2, req high at sample edge k SHALL give pending set after edge k+3 and irq=1 after edge k+4 (IDLE, unmasked).
REQ-015 A level held high SHALL set pending only once; a new set requires req to fall and rise again.
REQ-016 masked = pending AND NOT mask SHALL feed the priority encoder; code = index of highest set bit; zero flag = masked==0.
REQ-017 FSM states: IDLE, ASSERT, GAP.
REQ-018 IDLE: irq=0; if zero flag=0, latch encoder code into irq_code, go to ASSERT.
REQ-019 ASSERT: irq=1; irq_code SHALL stay stable even if a higher-priority line becomes pending or the mask changes.
REQ-020 ASSERT with ack=1: clear pending[irq_code] on that edge, go to GAP.
REQ-021 GAP: irq=0 for exactly one cycle, then IDLE.
REQ-022 ack in IDLE or GAP SHALL be ignored.
REQ-023 Same-edge set and ack-clear of the same bit: set wins (bit remains pending).
REQ-024 mask_wr=1 SHALL load mask_din on that edge in any state; it never retracts an asserted irq.
REQ-025 Masked lines SHALL still record pending; unmasking a pending line SHALL let it raise irq from IDLE.

Reset
REQ-026 rst_n=0 SHALL immediately force: state=IDLE, irq=0, irq_code=0, pending=8'h00, mask=8'h00, all synchroniser and edge-detect flops=0.
REQ-027 A req line already high at reset release SHALL be treated as a rising edge.
REQ-028 Reset asserted in ASSERT SHALL drop irq asynchronously and discard all pending state.

Structure
REQ-029 Shared package irq_pkg SHALL hold N_REQ=8, CODE_W=3 and the FSM state typedef.
REQ-030 The highest-set-bit encode SHALL be one instance of the existing PriorityEncode8 (in, code, z); no other sub-module.

Verification
REQ-031 Single request: mask=00, pulse req=8'h04 -> irq=1, irq_code=3'b010 at k+4; ack -> pending=00, irq=0 for GAP, stays 0.
REQ-032 Priority order: req=8'h41 same cycle -> irq_code=110; ack -> one GAP cycle, then irq_code=000; ack -> pending=00.
REQ-033 Stability: in ASSERT with code=001, raise req[7] -> irq_code stays 001 until ack; next grant is 111.
REQ-034 Masking: mask=8'h80, req[7] pulse -> pending=80, irq=0; write mask=00 -> irq=1, irq_code=111.
REQ-035 Set/clear collision: granted line 5 re-rises so its set edge coincides with ack -> pending[5] remains 1, re-granted after GAP.
REQ-036 Reset mid-operation: rst_n=0 while irq=1 -> irq=0 at once, pending=00, mask=00; held-high req after release -> new grant.
